spi_bus_responder: RTL and testbench

Memory-mapped SPI master peripheral that acts as a responder on the CPU memory bus. The CPU is the bus initiator: it drives address, write data, byte mask, bus_enable and write_enable, and samples read data one cycle later. The block decodes a 16-byte window at BASE_ADDR, holds TX/RX/control/status registers, and runs a mode-0, MSB-first, 8-bit SPI shift engine.

---
 rtl/spi_bus_responder_pkg.sv | 23 ++
 rtl/spi_bus_responder_if.sv | 19 +
 rtl/spi_bus_responder_shift_engine.sv | 118 +++++++++++
 rtl/spi_bus_responder.sv | 139 +++++++++++++
 tb/tb_spi_bus_responder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/spi_bus_responder_pkg.sv
// rtl/spi_bus_responder_pkg.sv - register offsets, status bits and shift FSM encoding for spi_bus_responder
package spi_bus_responder_pkg;

    localparam logic [1:0] REG_TX      = 2'd0;
    localparam logic [1:0] REG_RX      = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // A mask bit of 1 protects its byte lane.
    function automatic logic lane_en(input logic [3:0] mask, input int lane);
        return !mask[lane];
    endfunction

endpackage

// File: rtl/spi_bus_responder_if.sv
// rtl/spi_bus_responder_if.sv - CPU memory bus between initiator (master) and responder (slave)
interface spi_bus_responder_if;
    logic [15:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_mask;
    logic        bus_enable;
    logic        write_enable;
    logic [31:0] data_out;

    modport master (
        output address, data_in, write_mask, bus_enable, write_enable,
        input  data_out
    );

    modport slave (
        input  address, data_in, write_mask, bus_enable, write_enable,
        output data_out
    );
endinterface

// File: rtl/spi_bus_responder_shift_engine.sv
// rtl/spi_bus_responder_shift_engine.sv - mode-0 MSB-first 8-bit SPI shift engine
module spi_shift_engine
    import spi_bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic [7:0] div_i,
    input  logic       miso_i,
    output logic       spi_clk_o,
    output logic       mosi_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_byte_o
);

    logic [1:0] state_q,    state_d;
    logic [7:0] cnt_q,      cnt_d;
    logic [7:0] div_q,      div_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       sclk_q,     sclk_d;
    logic       mosi_q,     mosi_d;
    logic       busy_q,     busy_d;
    logic       half_done;

    assign half_done = (cnt_q == div_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // div is latched here so CONTROL writes mid-transfer wait for the next byte
                    tx_shift_d = tx_byte_i;
                    div_d      = div_i;
                    busy_d     = 1'b1;
                    mosi_d     = tx_byte_i[7];
                    cnt_d      = 8'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = ST_LOW;
                end
            end
            ST_LOW: begin
                if (half_done) begin
                    cnt_d      = 8'd0;
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], miso_i};
                    state_d    = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (half_done) begin
                    cnt_d  = 8'd0;
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        state_d    = ST_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            div_q      <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
        end
    end

    assign spi_clk_o = sclk_q;
    assign mosi_o    = mosi_q;
    assign busy_o    = busy_q;
    assign done_o    = (state_q == ST_DONE);
    assign rx_byte_o = rx_shift_q;

endmodule

// File: rtl/spi_bus_responder.sv
// rtl/spi_bus_responder.sv - memory-mapped SPI master: bus decode, registers, read mux
// Optional: SPI_BUS_RESPONDER_IRQ_EN adds irq output and CONTROL[9] irq_en.
module spi_bus_responder
    import spi_bus_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_bus_responder_if.slave   bus,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 spi_cs,
`ifdef SPI_BUS_RESPONDER_IRQ_EN
    output logic                 irq,
`endif
    input  logic                 spi_miso
);

    logic [7:0]  div_q,      div_d;
    logic        cs_q,       cs_d;
    logic        irq_en_q,   irq_en_d;
    logic        overrun_q,  overrun_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q,  rx_data_d;
    logic [31:0] data_out_q, data_out_d;

    logic       hit, wr, rd, tx_start;
    logic [1:0] offs;
    logic       busy, done;
    logic [7:0] rx_byte;
    wire        unused_bits = ^{bus.data_in[31:9], bus.address[1:0], bus.write_mask[3:2]};

    assign hit      = bus.bus_enable && (bus.address[15:4] == BASE_ADDR[15:4]);
    assign wr       = hit && bus.write_enable;
    assign rd       = hit && !bus.write_enable;
    assign offs     = bus.address[3:2];
    assign tx_start = wr && (offs == REG_TX) && lane_en(bus.write_mask, 0) && !busy;

    spi_shift_engine u_engine (
        .clk       (clk),
        .reset     (reset),
        .start_i   (tx_start),
        .tx_byte_i (bus.data_in[7:0]),
        .div_i     (div_q),
        .miso_i    (spi_miso),
        .spi_clk_o (spi_clk),
        .mosi_o    (spi_mosi),
        .busy_o    (busy),
        .done_o    (done),
        .rx_byte_o (rx_byte)
    );

    always_comb begin
        div_d      = div_q;
        cs_d       = cs_q;
        irq_en_d   = irq_en_q;
        overrun_d  = overrun_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        data_out_d = data_out_q;

        if (wr) begin
            case (offs)
                REG_TX: begin
                    if (lane_en(bus.write_mask, 0) && busy)
                        overrun_d = 1'b1;
                end
                REG_CONTROL: begin
                    if (lane_en(bus.write_mask, 0))
                        div_d = bus.data_in[7:0];
                    if (lane_en(bus.write_mask, 1)) begin
                        cs_d = bus.data_in[8];
`ifdef SPI_BUS_RESPONDER_IRQ_EN
                        irq_en_d = bus.data_in[9];
`endif
                    end
                end
                REG_STATUS: begin
                    if (lane_en(bus.write_mask, 0) && bus.data_in[STAT_OVERRUN])
                        overrun_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (offs)
                REG_RX: begin
                    data_out_d = {24'b0, rx_data_q};
                    rx_valid_d = 1'b0;
                end
                REG_CONTROL: data_out_d = {22'b0, irq_en_q, cs_q, div_q};
                REG_STATUS:  data_out_d = {29'b0, overrun_q, rx_valid_q, busy};
                default:     data_out_d = 32'b0;
            endcase
        end

        // A completing transfer outranks a concurrent RX read's clear.
        if (done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= DIV_RESET;
            cs_q       <= 1'b1;
            irq_en_q   <= 1'b0;
            overrun_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            data_out_q <= 32'd0;
        end else begin
            div_q      <= div_d;
            cs_q       <= cs_d;
            irq_en_q   <= irq_en_d;
            overrun_q  <= overrun_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef SPI_BUS_RESPONDER_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_en_q && rx_valid_q;
    end
    assign irq = irq_q;
`endif

    assign spi_cs       = cs_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_spi_bus_responder.sv
// tb/tb_spi_bus_responder.sv - directed self-checking bench for spi_bus_responder
module tb_spi_bus_responder;

    localparam logic [15:0] A_TX   = 16'h8000;
    localparam logic [15:0] A_RX   = 16'h8004;
    localparam logic [15:0] A_CTRL = 16'h8008;
    localparam logic [15:0] A_STAT = 16'h800C;

    logic clk = 1'b0;
    logic reset;
    logic spi_clk, spi_mosi, spi_cs, spi_miso;
`ifdef SPI_BUS_RESPONDER_IRQ_EN
    logic irq;
`endif
    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int p0;
    logic [7:0]  mosi_bits = 8'd0;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    spi_bus_responder_if bus ();

    // Loopback: every received bit equals the transmitted bit.
    assign spi_miso = spi_mosi;

    spi_bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_cs   (spi_cs),
`ifdef SPI_BUS_RESPONDER_IRQ_EN
        .irq      (irq),
`endif
        .spi_miso (spi_miso)
    );

    always @(posedge spi_clk) begin
        pulses    <= pulses + 1;
        mosi_bits <= {mosi_bits[6:0], spi_mosi};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.address      = a;
        bus.data_in      = d;
        bus.write_mask   = m;
        bus.bus_enable   = 1'b1;
        bus.write_enable = 1'b1;
        @(negedge clk);
        bus.bus_enable   = 1'b0;
        bus.write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        bus.address      = a;
        bus.write_mask   = 4'b0000;
        bus.bus_enable   = 1'b1;
        bus.write_enable = 1'b0;
        @(negedge clk);
        bus.bus_enable   = 1'b0;
        d = bus.data_out;
    endtask

    initial begin
        bus.address = 16'h0; bus.data_in = 32'h0; bus.write_mask = 4'h0;
        bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_cs", {31'b0, spi_cs}, 32'h1);
        check("rst_sclk", {31'b0, spi_clk}, 32'h0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'h0);
        reset = 1'b1;
        bus_read(A_STAT, rdata); check("rst_status", rdata, 32'h0);
        bus_read(A_CTRL, rdata); check("rst_control", rdata, 32'h103);

        // Accesses outside the window change nothing and leave data_out held.
        bus_write(16'h9008, 32'h0, 4'h0);
        bus_read(16'h900C, rdata); check("miss_hold", rdata, 32'h103);
        bus_read(A_CTRL, rdata);   check("miss_ctrl", rdata, 32'h103);

        // div=0 loopback transfer of 0xA5 with exact completion timing.
        bus_write(A_CTRL, 32'h000, 4'h0);
        check("cs_low", {31'b0, spi_cs}, 32'h0);
        p0 = pulses;
        bus_write(A_TX, 32'hA5, 4'h0);
        repeat (16) @(negedge clk);
        bus_read(A_STAT, rdata); check("a5_busy_t17", rdata, 32'h1);
        bus_read(A_STAT, rdata); check("a5_done_t18", rdata, 32'h2);
        check("a5_pulses", pulses - p0, 32'd8);
        check("a5_mosi", {24'b0, mosi_bits}, 32'hA5);
        bus_read(A_RX, rdata);   check("a5_rx", rdata, 32'hA5);
        bus_read(A_STAT, rdata); check("a5_stat_clr", rdata, 32'h0);

        // TX write while busy is dropped and flags overrun.
        p0 = pulses;
        bus_write(A_TX, 32'h3C, 4'h0);
        bus_write(A_TX, 32'hFF, 4'h0);
        repeat (20) @(negedge clk);
        bus_read(A_STAT, rdata); check("ovr_status", rdata, 32'h6);
        check("ovr_mosi", {24'b0, mosi_bits}, 32'h3C);
        check("ovr_pulses", pulses - p0, 32'd8);
        bus_write(A_STAT, 32'h4, 4'h0);
        bus_read(A_STAT, rdata); check("ovr_clear", rdata, 32'h2);
        bus_read(A_RX, rdata);   check("ovr_rx", rdata, 32'h3C);

        // Lane masking.
        p0 = pulses;
        bus_write(A_TX, 32'h55, 4'b0001);
        bus_read(A_STAT, rdata); check("mask_tx_idle", rdata, 32'h0);
        repeat (5) @(negedge clk);
        check("mask_tx_pulses", pulses - p0, 32'd0);
        bus_write(A_CTRL, 32'h1FF, 4'b0010);
        bus_read(A_CTRL, rdata); check("mask_ctrl", rdata, 32'h0FF);
        check("mask_cs", {31'b0, spi_cs}, 32'h0);
        bus_write(A_CTRL, 32'h3FF, 4'h0);
        bus_read(A_CTRL, rdata);
`ifdef SPI_BUS_RESPONDER_IRQ_EN
        check("ctrl_bit9", rdata, 32'h3FF);
`else
        check("ctrl_bit9", rdata, 32'h1FF);
`endif
        check("cs_high", {31'b0, spi_cs}, 32'h1);

        // Reset during bit 4 (div=1: bit k rises at write+4k+2).
        bus_write(A_CTRL, 32'h001, 4'h0);
        p0 = pulses;
        bus_write(A_TX, 32'h81, 4'h0);
        repeat (17) @(negedge clk);
        bus_read(A_STAT, rdata); check("mid_busy", rdata, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_sclk", {31'b0, spi_clk}, 32'h0);
        check("mid_cs", {31'b0, spi_cs}, 32'h1);
        check("mid_mosi", {31'b0, spi_mosi}, 32'h0);
        repeat (10) @(negedge clk);
        check("mid_pulses", pulses - p0, 32'd5);
        bus_read(A_STAT, rdata); check("mid_status", rdata, 32'h0);
        bus_read(A_RX, rdata);   check("mid_rx", rdata, 32'h0);
        bus_read(A_CTRL, rdata); check("mid_ctrl", rdata, 32'h103);

        // RX read in the DONE cycle sees the old byte; DONE still lands.
        bus_write(A_CTRL, 32'h000, 4'h0);
        bus_write(A_TX, 32'h5A, 4'h0);
        repeat (20) @(negedge clk);
        bus_read(A_RX, rdata); check("race_first", rdata, 32'h5A);
        bus_write(A_TX, 32'hC3, 4'h0);
        repeat (16) @(negedge clk);
        bus_read(A_RX, rdata);   check("race_old", rdata, 32'h5A);
        bus_read(A_STAT, rdata); check("race_valid", rdata, 32'h2);
        bus_read(A_RX, rdata);   check("race_new", rdata, 32'hC3);

`ifdef SPI_BUS_RESPONDER_IRQ_EN
        bus_write(A_CTRL, 32'h200, 4'h0);
        bus_write(A_TX, 32'h66, 4'h0);
        repeat (16) @(negedge clk);
        check("irq_t16", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_t17", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_t18", {31'b0, irq}, 32'h1);
        bus_read(A_RX, rdata); check("irq_rx", rdata, 32'h66);
        check("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'b0, irq}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
